// File: rtl/gameover_pkg.sv
// Shared types and banner geometry for the end-of-game banner controller.
package gameover_pkg;

  typedef enum logic [1:0] {W_P1, W_P2, W_DRAW} winner_t;
  typedef enum logic [1:0] {IDLE, SHOW, ARMED, DONE} state_t;

  localparam int P1_W  = 200;
  localparam int P1_H  = 34;
  localparam int P2_W  = 200;
  localparam int P2_H  = 34;
  localparam int DR_W  = 201;
  localparam int DR_H  = 56;
  localparam int P_AW  = 13;
  localparam int DR_AW = 14;

  // 00 is not a legal winner code; it falls back to a draw.
  function automatic winner_t decode_winner(input logic [1:0] code);
    case (code)
      2'b01:   return W_P1;
      2'b10:   return W_P2;
      default: return W_DRAW;
    endcase
  endfunction

endpackage

// File: rtl/gameover_addr_gen.sv
// Window test and linear ROM address for one banner anchored at (X0, Y0).
module gameover_addr_gen #(
  parameter int X0 = 300,
  parameter int Y0 = 250,
  parameter int W  = 200,
  parameter int H  = 34,
  parameter int AW = 13
) (
  input  logic [10:0]   hcount,
  input  logic [10:0]   vcount,
  output logic [AW-1:0] addr,
  output logic          in_win
);

  logic [10:0] rel_x;
  logic [10:0] rel_y;

  // Pixels left of / above the origin wrap to large values and fail the test.
  always_comb begin
    rel_x  = hcount - 11'(X0);
    rel_y  = vcount - 11'(Y0);
    in_win = (rel_x < 11'(W)) && (rel_y < 11'(H));
    addr   = '0;
    if (in_win) begin
      addr = AW'(rel_y) * AW'(W) + AW'(rel_x);
    end
  end

endmodule

// File: rtl/gameover_ctrl.sv
// End-of-game banner sequencer and VGA overlay.
// Optional: define GAMEOVER_BLINK_EN to blink the banner in ARMED every 30 frames.
module gameover_ctrl
  import gameover_pkg::*;
#(
  parameter int          BANNER_X    = 300,
  parameter int          BANNER_Y    = 250,
  parameter int          HOLD_FRAMES = 120,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [10:0]        hcount_in,
  input  logic [10:0]        vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic [11:0]        rgb_in,
  input  logic               game_over,
  input  logic [1:0]         winner,
  input  logic               restart_req,
  output logic [P_AW-1:0]    addr_p1,
  output logic [P_AW-1:0]    addr_p2,
  output logic [DR_AW-1:0]   addr_dr,
  input  logic [11:0]        rgb_p1,
  input  logic [11:0]        rgb_p2,
  input  logic [11:0]        rgb_draw,
  output logic [10:0]        hcount_out,
  output logic [10:0]        vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic [11:0]        rgb_out,
  output logic               banner_active,
  output logic               restart
);

  state_t      state_q, state_d;
  winner_t     winner_q, winner_d;
  winner_t     sel_q;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        de_q, de_d;
  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic [11:0] rgb_in_q;
  logic        win_q, win_d;
  logic        in_p1, in_p2, in_dr;
  logic        vsync_rise, vblnk_rise;
  logic        show_banner;
  logic [11:0] rom_px;

  gameover_addr_gen #(.X0(BANNER_X), .Y0(BANNER_Y), .W(P1_W), .H(P1_H), .AW(P_AW)) u_addr_p1 (
    .hcount(hcount_in), .vcount(vcount_in), .addr(addr_p1), .in_win(in_p1)
  );
  gameover_addr_gen #(.X0(BANNER_X), .Y0(BANNER_Y), .W(P2_W), .H(P2_H), .AW(P_AW)) u_addr_p2 (
    .hcount(hcount_in), .vcount(vcount_in), .addr(addr_p2), .in_win(in_p2)
  );
  gameover_addr_gen #(.X0(BANNER_X), .Y0(BANNER_Y), .W(DR_W), .H(DR_H), .AW(DR_AW)) u_addr_dr (
    .hcount(hcount_in), .vcount(vcount_in), .addr(addr_dr), .in_win(in_dr)
  );

  // The delayed timing flops double as the previous-cycle samples for edge detection.
  assign vsync_rise    = vsync_in & ~vsync_q;
  assign vblnk_rise    = vblnk_in & ~vblnk_q;
  assign banner_active = (state_q == SHOW) || (state_q == ARMED);
  assign restart       = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        frame_cnt_d = '0;
        if (game_over) begin
          state_d  = SHOW;
          winner_d = decode_winner(winner);
        end
      end
      SHOW: begin
        if (vsync_rise) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (frame_cnt_q + 8'd1 == 8'(HOLD_FRAMES)) begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (restart_req) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d     = IDLE;
        frame_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef GAMEOVER_BLINK_EN
  localparam logic [4:0] BLINK_LAST = 5'd29;
  logic [4:0] blink_cnt_q, blink_cnt_d;
  logic       blink_vis_q, blink_vis_d;

  // Outside ARMED the blink phase is held at "visible, count 0" so entry starts visible.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_vis_d = blink_vis_q;
    if (state_q != ARMED) begin
      blink_cnt_d = '0;
      blink_vis_d = 1'b1;
    end else if (vsync_rise) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_vis_d = ~blink_vis_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_vis_q <= blink_vis_d;
    end
  end

  assign show_banner = (state_q == SHOW) || ((state_q == ARMED) && blink_vis_q);
`else
  assign show_banner = banner_active;
`endif

  // Enable only changes at the start of vertical blanking so a frame is never torn.
  always_comb begin
    de_d = de_q;
    if (vblnk_rise) begin
      de_d = show_banner;
    end
    case (winner_q)
      W_P1:    win_d = in_p1;
      W_P2:    win_d = in_p2;
      default: win_d = in_dr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      winner_q    <= W_DRAW;
      sel_q       <= W_DRAW;
      frame_cnt_q <= '0;
      de_q        <= 1'b0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      rgb_in_q    <= '0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      sel_q       <= winner_q;
      frame_cnt_q <= frame_cnt_d;
      de_q        <= de_d;
      hcount_q    <= hcount_in;
      vcount_q    <= vcount_in;
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
      hblnk_q     <= hblnk_in;
      vblnk_q     <= vblnk_in;
      rgb_in_q    <= rgb_in;
      win_q       <= win_d;
    end
  end

  // Stage 1: ROM data arrives aligned with the delayed timing.
  always_comb begin
    case (sel_q)
      W_P1:    rom_px = rgb_p1;
      W_P2:    rom_px = rgb_p2;
      default: rom_px = rgb_draw;
    endcase
    if (hblnk_q || vblnk_q) begin
      rgb_out = '0;
    end else if (de_q && win_q && (rom_px != KEY_COLOR)) begin
      rgb_out = rom_px;
    end else begin
      rgb_out = rgb_in_q;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign hblnk_out  = hblnk_q;
  assign vblnk_out  = vblnk_q;

endmodule

// File: tb/tb_gameover_ctrl.sv
// Directed bench for gameover_ctrl: reset, overlay, keying, blanking, hold/restart, reset mid-show.
module tb_gameover_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        game_over;
  logic [1:0]  winner;
  logic        restart_req;
  logic [12:0] addr_p1, addr_p2;
  logic [13:0] addr_dr;
  logic [11:0] rgb_p1, rgb_p2, rgb_draw;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        banner_active, restart;

  int total = 0;
  int bad   = 0;

  gameover_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .game_over(game_over), .winner(winner), .restart_req(restart_req),
    .addr_p1(addr_p1), .addr_p2(addr_p2), .addr_dr(addr_dr),
    .rgb_p1(rgb_p1), .rgb_p2(rgb_p2), .rgb_draw(rgb_draw),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .banner_active(banner_active), .restart(restart)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic set_pix(input int h, input int v);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
  endtask

  // One frame boundary: a single vblnk rising edge and a single vsync rising edge.
  task automatic frame_edge();
    @(negedge clk);
    vblnk_in = 1'b1;
    vsync_in = 1'b1;
    @(negedge clk);
    vblnk_in = 1'b0;
    vsync_in = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_pix(5, 7);
    hsync_in = 1'b1;
    rgb_in   = 12'hABC;
    @(negedge clk); #1;
    total++; if (hcount_out !== 11'd0) begin bad++; $display("FAIL rst_hcount got=%0d want=0", hcount_out); end
    total++; if (hsync_out !== 1'b0) begin bad++; $display("FAIL rst_hsync got=%b want=0", hsync_out); end
    total++; if (rgb_out !== 12'h000) begin bad++; $display("FAIL rst_rgb got=%h want=000", rgb_out); end
    total++; if (banner_active !== 1'b0) begin bad++; $display("FAIL rst_active got=%b want=0", banner_active); end
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL rst_restart got=%b want=0", restart); end
    @(negedge clk);
    rst_n    = 1'b1;
    hsync_in = 1'b0;
    @(negedge clk); #1;
    total++; if (hcount_out !== 11'd5) begin bad++; $display("FAIL post_rst_hcount got=%0d want=5", hcount_out); end
    total++; if (rgb_out !== 12'hABC) begin bad++; $display("FAIL post_rst_rgb got=%h want=abc", rgb_out); end
  endtask

  task automatic test_p1_banner();
    @(negedge clk);
    winner    = 2'b01;
    game_over = 1'b1;
    set_pix(0, 0);
    @(negedge clk);
    game_over = 1'b0;
    winner    = 2'b00;
    #1;
    total++; if (banner_active !== 1'b1) begin bad++; $display("FAIL active_after_go got=%b want=1", banner_active); end
    set_pix(300, 250);
    rgb_in = 12'h111;
    @(negedge clk);
    rgb_p1 = 12'h0A5;
    #1;
    total++; if (rgb_out !== 12'h111) begin bad++; $display("FAIL no_midframe_banner got=%h want=111", rgb_out); end
    frame_edge();
    @(negedge clk);
    set_pix(300, 250);
    rgb_in = 12'h222;
    #1;
    total++; if (addr_p1 !== 13'd0) begin bad++; $display("FAIL p1_origin_addr got=%0d want=0", addr_p1); end
    @(negedge clk);
    rgb_p1 = 12'h0A5;
    set_pix(499, 283);
    rgb_in = 12'h456;
    #1;
    total++; if (rgb_out !== 12'h0A5) begin bad++; $display("FAIL p1_pixel got=%h want=0a5", rgb_out); end
    total++; if (addr_p1 !== 13'd6799) begin bad++; $display("FAIL p1_last_addr got=%0d want=6799", addr_p1); end
    total++; if (addr_p2 !== 13'd6799) begin bad++; $display("FAIL p2_last_addr got=%0d want=6799", addr_p2); end
    @(negedge clk);
    rgb_p1 = 12'hF0F;
    set_pix(500, 283);
    rgb_in = 12'h777;
    #1;
    total++; if (rgb_out !== 12'h456) begin bad++; $display("FAIL key_passthru got=%h want=456", rgb_out); end
    total++; if (addr_p1 !== 13'd0) begin bad++; $display("FAIL p1_right_outside got=%0d want=0", addr_p1); end
    @(negedge clk);
    rgb_p1   = 12'h0A5;
    set_pix(300, 251);
    hblnk_in = 1'b1;
    rgb_in   = 12'h888;
    #1;
    total++; if (rgb_out !== 12'h777) begin bad++; $display("FAIL outside_window_rgb got=%h want=777", rgb_out); end
    @(negedge clk);
    hblnk_in = 1'b0;
    set_pix(500, 305);
    rgb_in = 12'h999;
    #1;
    total++; if (rgb_out !== 12'h000) begin bad++; $display("FAIL hblank_black got=%h want=000", rgb_out); end
    total++; if (addr_dr !== 14'd11255) begin bad++; $display("FAIL dr_addr_indep got=%0d want=11255", addr_dr); end
    @(negedge clk);
    set_pix(300, 249);
    #1;
    total++; if (addr_p1 !== 13'd0) begin bad++; $display("FAIL p1_above_wrap got=%0d want=0", addr_p1); end
  endtask

  task automatic test_restart_in_show();
    repeat (49) frame_edge();
    @(negedge clk);
    restart_req = 1'b1;
    @(negedge clk);
    restart_req = 1'b0;
    #1;
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL restart_in_show got=%b want=0", restart); end
    total++; if (banner_active !== 1'b1) begin bad++; $display("FAIL still_show got=%b want=1", banner_active); end
  endtask

  task automatic test_second_game_over();
    @(negedge clk);
    game_over = 1'b1;
    winner    = 2'b10;
    @(negedge clk);
    game_over = 1'b0;
    winner    = 2'b00;
    set_pix(300, 250);
    rgb_in = 12'h333;
    @(negedge clk);
    rgb_p1   = 12'h0A5;
    rgb_p2   = 12'h0B6;
    rgb_draw = 12'h3C3;
    #1;
    total++; if (rgb_out !== 12'h0A5) begin bad++; $display("FAIL winner_not_relatched got=%h want=0a5", rgb_out); end
  endtask

  task automatic test_hold_and_restart();
    repeat (69) frame_edge();
    @(negedge clk);
    restart_req = 1'b1;
    @(negedge clk);
    restart_req = 1'b0;
    #1;
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL restart_at_119 got=%b want=0", restart); end
    frame_edge();
    @(negedge clk);
    restart_req = 1'b1;
    game_over   = 1'b1;
    winner      = 2'b10;
    @(negedge clk);
    restart_req = 1'b0;
    game_over   = 1'b0;
    winner      = 2'b00;
    #1;
    total++; if (restart !== 1'b1) begin bad++; $display("FAIL restart_pulse got=%b want=1", restart); end
    total++; if (banner_active !== 1'b0) begin bad++; $display("FAIL active_in_done got=%b want=0", banner_active); end
    @(negedge clk);
    set_pix(300, 250);
    rgb_in = 12'h444;
    #1;
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL restart_width got=%b want=0", restart); end
    total++; if (banner_active !== 1'b0) begin bad++; $display("FAIL idle_after_done got=%b want=0", banner_active); end
    @(negedge clk);
    rgb_p1 = 12'h0A5;
    #1;
    total++; if (rgb_out !== 12'h0A5) begin bad++; $display("FAIL banner_until_frame_end got=%h want=0a5", rgb_out); end
    frame_edge();
    @(negedge clk);
    set_pix(300, 250);
    rgb_in = 12'h555;
    @(negedge clk); #1;
    total++; if (rgb_out !== 12'h555) begin bad++; $display("FAIL banner_gone got=%h want=555", rgb_out); end
  endtask

  task automatic test_draw();
    @(negedge clk);
    game_over = 1'b1;
    winner    = 2'b11;
    @(negedge clk);
    game_over = 1'b0;
    winner    = 2'b00;
    frame_edge();
    @(negedge clk);
    set_pix(500, 305);
    rgb_in = 12'h606;
    #1;
    total++; if (addr_dr !== 14'd11255) begin bad++; $display("FAIL dr_last_addr got=%0d want=11255", addr_dr); end
    @(negedge clk);
    rgb_draw = 12'h3C3;
    rgb_p1   = 12'h0A5;
    set_pix(501, 305);
    rgb_in = 12'h707;
    #1;
    total++; if (rgb_out !== 12'h3C3) begin bad++; $display("FAIL draw_pixel got=%h want=3c3", rgb_out); end
    total++; if (addr_dr !== 14'd0) begin bad++; $display("FAIL dr_outside_addr got=%0d want=0", addr_dr); end
    @(negedge clk); #1;
    total++; if (rgb_out !== 12'h707) begin bad++; $display("FAIL dr_outside_rgb got=%h want=707", rgb_out); end
  endtask

  task automatic test_reset_mid_show();
    @(negedge clk);
    set_pix(500, 305);
    rgb_in = 12'h808;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (banner_active !== 1'b0) begin bad++; $display("FAIL async_rst_active got=%b want=0", banner_active); end
    total++; if (rgb_out !== 12'h000) begin bad++; $display("FAIL async_rst_rgb got=%h want=000", rgb_out); end
    total++; if (hcount_out !== 11'd0) begin bad++; $display("FAIL async_rst_hcount got=%0d want=0", hcount_out); end
    @(negedge clk);
    rst_n  = 1'b1;
    rgb_in = 12'h5A5;
    @(negedge clk);
    rgb_draw = 12'h3C3;
    #1;
    total++; if (rgb_out !== 12'h5A5) begin bad++; $display("FAIL post_rst_passthru got=%h want=5a5", rgb_out); end
    total++; if (banner_active !== 1'b0) begin bad++; $display("FAIL post_rst_idle got=%b want=0", banner_active); end
  endtask

  initial begin
    rst_n       = 1'b0;
    hcount_in   = '0;
    vcount_in   = '0;
    hsync_in    = 1'b0;
    vsync_in    = 1'b0;
    hblnk_in    = 1'b0;
    vblnk_in    = 1'b0;
    rgb_in      = '0;
    game_over   = 1'b0;
    winner      = 2'b00;
    restart_req = 1'b0;
    rgb_p1      = '0;
    rgb_p2      = '0;
    rgb_draw    = '0;
    test_reset();
    test_p1_banner();
    test_restart_in_show();
    test_second_game_over();
    test_hold_and_restart();
    test_draw();
    test_reset_mid_show();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
